morse_keyer_ctrl: RTL and testbench

Sequencing controller for the Morse receive path. It measures the duration of each key press and each gap in prescaled time units, and classifies each press as a dot or a dash. It also drives the enables of the element shift register and the letter output register. A completed letter is presented to the character lookup stage over a valid/ready handshake, and a one-cycle pulse marks each word gap.

---
 rtl/morse_pkg.sv | 19 +
 rtl/morse_en_reg.sv | 21 ++
 rtl/morse_tick_gen.sv | 23 ++
 rtl/morse_keyer_ctrl.sv | 142 ++++++++++++++
 tb/tb_morse_keyer_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/morse_pkg.sv
// Shared types and sizes for the Morse receive-path sequencing logic.
package morse_pkg;
  localparam int MAX_ELEMS = 5;
  localparam int PAT_W     = 5;
  localparam int LEN_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    GAP_IN,
    GAP_WORD
  } state_e;

  typedef struct packed {
    logic             err;
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pattern;
  } letter_t;
endpackage

// File: rtl/morse_en_reg.sv
// Enabled register cell: loads d when en is high, otherwise holds.
module morse_en_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] data_q, data_d;

  always_comb data_d = en ? d : data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;
endmodule

// File: rtl/morse_tick_gen.sv
// Free-running prescaler; tick is high for the last clk cycle of each time unit.
module morse_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/morse_keyer_ctrl.sv
// Times key marks/spaces in ticks, collects dot/dash elements into letters and
// hands each letter to the lookup stage over valid/ready; pulses on word gaps.
module morse_keyer_ctrl
  import morse_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int DASH_MIN   = 2,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7,
  parameter int CW         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key,
  output logic [PAT_W-1:0] out_pattern,
  output logic [LEN_W-1:0] out_len,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             word_gap,
  output logic             overrun
);
  localparam logic [CW-1:0] DASH_LEN = CW'(DASH_MIN);
  localparam logic [CW-1:0] LG_LAST  = CW'(LETTER_GAP - 1);
  localparam logic [CW-1:0] WG_LAST  = CW'(WORD_GAP - 1);

  logic          tick, rise, fall;
  logic          key_q, key_d;
  logic [CW-1:0] dur_q, dur_d;
  state_e        state_q, state_d;
  logic          append, emit, load_out, store_en;
  logic          out_valid_q, out_valid_d;
  logic          word_gap_q, word_gap_d;
  logic          overrun_q, overrun_d;
  letter_t       store_q, store_d, letter_q;

  morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_comb begin
    key_d = key;
    rise  = key & ~key_q;
    fall  = ~key & key_q;
    dur_d = dur_q;
    if (rise | fall)               dur_d = '0;
    else if (tick && dur_q != '1)  dur_d = dur_q + CW'(1);
  end

  // Rise is tested first in the gap states so that a new mark always wins over an emit tick.
  always_comb begin
    state_d    = state_q;
    append     = 1'b0;
    emit       = 1'b0;
    word_gap_d = 1'b0;
    case (state_q)
      IDLE:     if (rise) state_d = MARK;
      MARK:     if (fall) begin
                  append  = 1'b1;
                  state_d = GAP_IN;
                end
      GAP_IN:   if (rise) state_d = MARK;
                else if (tick && dur_q == LG_LAST) begin
                  emit    = 1'b1;
                  state_d = GAP_WORD;
                end
      GAP_WORD: if (rise) state_d = MARK;
                else if (tick && dur_q == WG_LAST) begin
                  word_gap_d = 1'b1;
                  state_d    = IDLE;
                end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    store_en = append | emit;
    store_d  = store_q;
    if (emit) begin
      store_d = '0;
    end else if (append) begin
      if (store_q.len == LEN_W'(MAX_ELEMS)) begin
        store_d.err = 1'b1;
      end else begin
        store_d.pattern = store_q.pattern | (PAT_W'(dur_q >= DASH_LEN) << store_q.len);
        store_d.len     = store_q.len + LEN_W'(1);
      end
    end
  end

  // A held letter may be replaced only in the same cycle it is being accepted.
  always_comb begin
    load_out    = emit & (~out_valid_q | out_ready);
    overrun_d   = emit & ~load_out;
    out_valid_d = out_valid_q;
    if (load_out)       out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  morse_en_reg #(.W($bits(letter_t))) u_store (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (store_en),
    .d    (store_d),
    .q    (store_q)
  );

  morse_en_reg #(.W($bits(letter_t))) u_out (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (load_out),
    .d    (store_q),
    .q    (letter_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= 1'b0;
      dur_q       <= '0;
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      word_gap_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      key_q       <= key_d;
      dur_q       <= dur_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      word_gap_q  <= word_gap_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_pattern = letter_q.pattern;
  assign out_len     = letter_q.len;
  assign out_err     = letter_q.err;
  assign out_valid   = out_valid_q;
  assign word_gap    = word_gap_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// Bench for morse_keyer_ctrl: directed letter scenarios plus random keying,
// every cycle compared against an element-list reference model.
module tb_morse_keyer_ctrl;
  localparam int TICK_DIV   = 4;
  localparam int DASH_MIN   = 2;
  localparam int LETTER_GAP = 3;
  localparam int WORD_GAP   = 7;
  localparam int CW         = 8;

  logic       clk = 1'b0;
  logic       rst_n, key, out_ready;
  logic [4:0] out_pattern;
  logic [2:0] out_len;
  logic       out_err, out_valid, word_gap, overrun;

  int vectors = 0;
  int miscompares = 0;
  int wg_cnt = 0;
  int ovr_cnt = 0;
  logic [8:0] acc_q[$];

  // reference model state
  int         m_ph, m_dur;
  bit         m_kq, m_err, m_await, m_ov, m_wg, m_ovr;
  bit         m_q[$];
  logic [8:0] m_held;

  morse_keyer_ctrl #(
    .TICK_DIV(TICK_DIV), .DASH_MIN(DASH_MIN), .LETTER_GAP(LETTER_GAP),
    .WORD_GAP(WORD_GAP), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key),
    .out_pattern(out_pattern), .out_len(out_len), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .word_gap(word_gap), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_ph = 0; m_dur = 0; m_kq = 0; m_err = 0; m_await = 0;
    m_ov = 0; m_wg = 0; m_ovr = 0; m_held = '0;
    m_q.delete();
  endfunction

  function automatic void model_step(input bit k, input bit rdy);
    bit rise, fall, tick, pend, emit;
    logic [8:0] let_v;
    rise = k && !m_kq;
    fall = !k && m_kq;
    tick = (m_ph == TICK_DIV - 1);
    pend = (m_q.size() != 0);
    emit = 0; m_wg = 0; m_ovr = 0;
    if (fall) begin
      if (m_q.size() < 5) m_q.push_back(m_dur >= DASH_MIN);
      else m_err = 1;
    end else if (!m_kq && !rise && tick) begin
      if (pend && m_dur + 1 == LETTER_GAP) begin
        emit = 1; m_await = 1;
      end else if (!pend && m_await && m_dur + 1 == WORD_GAP) begin
        m_wg = 1; m_await = 0;
      end
    end
    if (emit) begin
      let_v = '0;
      foreach (m_q[i]) let_v[i] = m_q[i];
      let_v[7:5] = 3'(m_q.size());
      let_v[8] = m_err;
      m_q.delete(); m_err = 0;
      if (!m_ov || rdy) begin m_held = let_v; m_ov = 1; end
      else m_ovr = 1;
    end else if (m_ov && rdy) begin
      m_ov = 0;
    end
    if (rise || fall) m_dur = 0;
    else if (tick && m_dur < (1 << CW) - 1) m_dur++;
    m_kq = k;
    m_ph = (m_ph + 1) % TICK_DIV;
  endfunction

  function automatic bit would_emit();
    return !key && !m_kq && (m_q.size() != 0) && (m_ph == TICK_DIV - 1) &&
           (m_dur + 1 == LETTER_GAP);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      if (rst_n && out_valid && out_ready) acc_q.push_back({out_err, out_len, out_pattern});
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step(key, out_ready);
      #1;
      wg_cnt  += int'(word_gap);
      ovr_cnt += int'(overrun);
      chk("cycle", 32'({out_valid, out_err, out_len, out_pattern, word_gap, overrun}),
          32'({m_ov, m_held, m_wg, m_ovr}));
    end
  endtask

  task automatic mark_space(input int hi, input int lo);
    key = 1'b1; cyc(hi);
    key = 1'b0; cyc(lo);
  endtask

  initial begin
    bit found;
    rst_n = 1'b1; key = 1'b0; out_ready = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;

    // reset held with key toggling
    for (int i = 0; i < 6; i++) begin key = i[0]; cyc(1); end
    chk("reset_outs", 32'({out_valid, out_err, out_len, out_pattern, word_gap, overrun}), 32'd0);
    key = 1'b0; rst_n = 1'b1;
    cyc(20);
    chk("idle_after_reset", 32'(dut.state_q), 32'(morse_pkg::IDLE));
    chk("idle_no_valid", 32'(out_valid), 32'd0);

    // letter A: dot, dash, then long space
    out_ready = 1'b1; acc_q.delete(); wg_cnt = 0;
    mark_space(4, 4);
    mark_space(12, 40);
    chk("A_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) chk("A_letter", 32'(acc_q[0]), 32'h0_4_2);
    chk("A_word_gap", 32'(wg_cnt), 32'd1);

    // six dots overflow the element store
    acc_q.delete();
    for (int i = 0; i < 5; i++) mark_space(4, 4);
    mark_space(4, 40);
    chk("ovf_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) chk("ovf_letter", 32'(acc_q[0]), 32'h1A0);

    // backpressure: E held, T dropped
    out_ready = 1'b0; acc_q.delete(); ovr_cnt = 0;
    mark_space(4, 16);
    mark_space(12, 40);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_held_E", 32'({out_err, out_len, out_pattern}), 32'h020);
    chk("bp_overrun", 32'(ovr_cnt), 32'd1);
    out_ready = 1'b1;
    cyc(1);
    chk("bp_accept", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) chk("bp_accept_E", 32'(acc_q[0]), 32'h020);
    chk("bp_valid_fall", 32'(out_valid), 32'd0);
    cyc(4);

    // ready coincides with the second emit
    out_ready = 1'b0; acc_q.delete(); ovr_cnt = 0;
    mark_space(4, 16);
    key = 1'b1; cyc(12);
    key = 1'b0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (would_emit()) begin
        out_ready = 1'b1; cyc(1); out_ready = 1'b0; found = 1;
      end else begin
        cyc(1);
      end
    end
    chk("sim_emit_seen", 32'(found), 32'd1);
    chk("sim_accept", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) chk("sim_accept_E", 32'(acc_q[0]), 32'h020);
    chk("sim_valid", 32'(out_valid), 32'd1);
    chk("sim_held_T", 32'({out_err, out_len, out_pattern}), 32'h021);
    chk("sim_no_overrun", 32'(ovr_cnt), 32'd0);
    cyc(30);
    out_ready = 1'b1; cyc(4);

    // reset during the third element
    acc_q.delete();
    mark_space(4, 4);
    mark_space(4, 4);
    key = 1'b1; cyc(3);
    rst_n = 1'b0; cyc(2);
    key = 1'b0; rst_n = 1'b1;
    cyc(40);
    chk("rst_mid_no_letter", 32'(acc_q.size()), 32'd0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_state", 32'(dut.state_q), 32'(morse_pkg::IDLE));

    // random keying with random consumer readiness
    for (int n = 0; n < 80; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      key = 1'b1; cyc($urandom_range(1, 16));
      key = 1'b0;
      if ($urandom_range(0, 2) == 0) cyc($urandom_range(10, 40));
      else cyc($urandom_range(1, 9));
    end
    out_ready = 1'b1; cyc(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
